// File: rtl/vrf_wb_seq.sv
// Writeback sequencer: buffers up to two lane result packets and streams them,
// one element per cycle, into the vector register file write port.
module vrf_wb_seq #(
  parameter  int DATA_WIDTH = 32,
  parameter  int REG_NUM    = 32,
  parameter  int LANES      = 4,
  localparam int ADDR_B     = $clog2(REG_NUM),
  localparam int ELEM_B     = $clog2(LANES)
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [ADDR_B-1:0]             res_addr_i,
  input  logic [LANES*DATA_WIDTH-1:0]   res_data_i,
  input  logic [LANES-1:0]              res_mask_i,
  input  logic [ADDR_B-1:0]             hazard_addr_i,
  output logic                          hazard_o,
  output logic                          wr_req_o,
  output logic                          wr_en_o,
  output logic                          wr_ready_o,
  output logic [ELEM_B-1:0]             wr_elem_cnt_o,
  output logic [ADDR_B-1:0]             wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t                        r_state;
  state_t                        w_nextState;
  logic [ADDR_B-1:0]             r_addr [2];
  logic [LANES*DATA_WIDTH-1:0]   r_data [2];
  logic [LANES-1:0]              r_mask [2];
  logic [1:0]                    r_valid;
  logic                          r_rdPtr;
  logic                          r_wrPtr;
  logic [ELEM_B-1:0]             r_cnt;

  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_headValid;
  logic [ADDR_B-1:0]             w_headAddr;
  logic [LANES*DATA_WIDTH-1:0]   w_headData;
  logic [LANES-1:0]              w_headMask;
  logic                          w_nextValid;
  logic [LANES-1:0]              w_nextMask;
  logic                          w_lastElem;

  assign w_full      = &r_valid;
  assign w_headValid = r_valid[r_rdPtr];
  assign w_headAddr  = r_addr[r_rdPtr];
  assign w_headData  = r_data[r_rdPtr];
  assign w_headMask  = r_mask[r_rdPtr];
  assign w_nextValid = r_valid[~r_rdPtr];
  assign w_nextMask  = r_mask[~r_rdPtr];
  assign w_lastElem  = (r_cnt == ELEM_B'(LANES - 1));

  // Ready depends only on registered occupancy, so a pop frees space next cycle.
  assign res_ready_o = resetn_i && !w_full;
  assign w_push      = res_valid_i && res_ready_o;
  assign busy_o      = |r_valid;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_valid <= '0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_wrPtr]  <= res_addr_i;
        r_data[r_wrPtr]  <= res_data_i;
        r_mask[r_wrPtr]  <= res_mask_i;
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= ~r_rdPtr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= (r_state == WRITE) ? r_cnt + 1'b1 : '0;
    end
  end

  // A queued packet with work chains straight into REQ, keeping bursts LANES+1 apart.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_headValid) begin
          if (w_headMask == '0) w_pop = 1'b1;
          else                  w_nextState = REQ;
        end
      end
      REQ:   w_nextState = WRITE;
      WRITE: begin
        if (w_lastElem) begin
          w_pop       = 1'b1;
          w_nextState = (w_nextValid && (w_nextMask != '0)) ? REQ : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    wr_req_o      = 1'b0;
    wr_en_o       = 1'b0;
    wr_ready_o    = 1'b0;
    wr_elem_cnt_o = '0;
    wr_addr_o     = '0;
    wdata_o       = '0;
    case (r_state)
      REQ: begin
        wr_req_o  = 1'b1;
        wr_addr_o = w_headAddr;
      end
      WRITE: begin
        wr_en_o       = w_headMask[r_cnt];
        wr_ready_o    = w_lastElem;
        wr_elem_cnt_o = r_cnt;
        wr_addr_o     = w_headAddr;
        wdata_o       = w_headData[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (r_valid[i] && (r_addr[i] == hazard_addr_i)) hazard_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_vrf_wb_seq.sv
// Directed self-checking bench for vrf_wb_seq with LANES=4, 32-bit elements.
module tb_vrf_wb_seq;

  logic         clk_i = 1'b0;
  logic         resetn_i;
  logic         res_valid_i;
  logic         res_ready_o;
  logic [4:0]   res_addr_i;
  logic [127:0] res_data_i;
  logic [3:0]   res_mask_i;
  logic [4:0]   hazard_addr_i;
  logic         hazard_o;
  logic         wr_req_o;
  logic         wr_en_o;
  logic         wr_ready_o;
  logic [1:0]   wr_elem_cnt_o;
  logic [4:0]   wr_addr_o;
  logic [31:0]  wdata_o;
  logic         busy_o;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  vrf_wb_seq #(.DATA_WIDTH(32), .REG_NUM(32), .LANES(4)) dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_addr_i    (res_addr_i),
    .res_data_i    (res_data_i),
    .res_mask_i    (res_mask_i),
    .hazard_addr_i (hazard_addr_i),
    .hazard_o      (hazard_o),
    .wr_req_o      (wr_req_o),
    .wr_en_o       (wr_en_o),
    .wr_ready_o    (wr_ready_o),
    .wr_elem_cnt_o (wr_elem_cnt_o),
    .wr_addr_o     (wr_addr_o),
    .wdata_o       (wdata_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] addr,
                               input logic [127:0] data, input logic [3:0] mask);
    res_valid_i = valid;
    res_addr_i  = addr;
    res_data_i  = data;
    res_mask_i  = mask;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walks one full packet starting from its REQ cycle sample.
  task automatic checkPacket(input string tag, input logic [4:0] addr,
                             input logic [3:0] mask, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3);
    logic [31:0] expW [4];
    expW[0] = w0; expW[1] = w1; expW[2] = w2; expW[3] = w3;
    checkOutput({tag, "_req"}, {31'd0, wr_req_o}, 32'd1);
    checkOutput({tag, "_reqAddr"}, {27'd0, wr_addr_o}, {27'd0, addr});
    checkOutput({tag, "_reqEn"}, {31'd0, wr_en_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput({tag, "_cnt"}, {30'd0, wr_elem_cnt_o}, k);
      checkOutput({tag, "_wdata"}, wdata_o, expW[k]);
      checkOutput({tag, "_en"}, {31'd0, wr_en_o}, {31'd0, mask[k]});
      checkOutput({tag, "_ready"}, {31'd0, wr_ready_o}, (k == 3) ? 32'd1 : 32'd0);
      checkOutput({tag, "_noReq"}, {31'd0, wr_req_o}, 32'd0);
      checkOutput({tag, "_addr"}, {27'd0, wr_addr_o}, {27'd0, addr});
    end
  endtask

  initial begin
    logic [31:0] reqSeen;
    logic [31:0] rdySeen;
    int          acceptAt;
    int          overlap;
    logic        acc;
    logic        anyWr;

    resetn_i      = 1'b0;
    hazard_addr_i = '0;
    applyStimulus(1'b0, 5'd0, 128'd0, 4'd0);
    #1;
    checkOutput("rst_ready", {31'd0, res_ready_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_req", {31'd0, wr_req_o}, 32'd0);
    checkOutput("rst_hazard", {31'd0, hazard_o}, 32'd0);
    tick();
    tick();
    #2 resetn_i = 1'b1;
    tick();
    checkOutput("post_rst_ready", {31'd0, res_ready_o}, 32'd1);
    checkOutput("post_rst_addr", {27'd0, wr_addr_o}, 32'd0);

    $display("[TB] single full-mask packet");
    applyStimulus(1'b1, 5'd5, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF);
    tick();
    applyStimulus(1'b0, 5'd0, 128'd0, 4'd0);
    checkOutput("t1_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("t1_idleReq", {31'd0, wr_req_o}, 32'd0);
    tick();
    checkPacket("t1", 5'd5, 4'hF, 32'h11, 32'h22, 32'h33, 32'h44);
    tick();
    checkOutput("t1_busyFall", {31'd0, busy_o}, 32'd0);
    checkOutput("t1_readyLow", {31'd0, wr_ready_o}, 32'd0);
    checkOutput("t1_addrIdle", {27'd0, wr_addr_o}, 32'd0);

    $display("[TB] partial mask packet");
    applyStimulus(1'b1, 5'd9, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b0101);
    tick();
    applyStimulus(1'b0, 5'd0, 128'd0, 4'd0);
    tick();
    checkPacket("t2", 5'd9, 4'b0101, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();
    checkOutput("t2_busyFall", {31'd0, busy_o}, 32'd0);

    $display("[TB] zero mask packet");
    hazard_addr_i = 5'd3;
    applyStimulus(1'b1, 5'd3, {32'h4, 32'h3, 32'h2, 32'h1}, 4'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 128'd0, 4'd0);
    checkOutput("t3_hazard", {31'd0, hazard_o}, 32'd1);
    checkOutput("t3_busy", {31'd0, busy_o}, 32'd1);
    tick();
    checkOutput("t3_hazardClr", {31'd0, hazard_o}, 32'd0);
    checkOutput("t3_busyClr", {31'd0, busy_o}, 32'd0);
    checkOutput("t3_noReq", {31'd0, wr_req_o}, 32'd0);
    tick();
    checkOutput("t3_noReq2", {31'd0, wr_req_o}, 32'd0);
    checkOutput("t3_noEn", {31'd0, wr_en_o}, 32'd0);

    $display("[TB] three packets back to back");
    applyStimulus(1'b1, 5'd1, {32'h14, 32'h13, 32'h12, 32'h11}, 4'hF);
    tick();
    checkOutput("t4_readyOne", {31'd0, res_ready_o}, 32'd1);
    applyStimulus(1'b1, 5'd2, {32'h24, 32'h23, 32'h22, 32'h21}, 4'hF);
    tick();
    checkOutput("t4_readyFull", {31'd0, res_ready_o}, 32'd0);
    applyStimulus(1'b1, 5'd3, {32'h34, 32'h33, 32'h32, 32'h31}, 4'hF);
    reqSeen  = '0;
    rdySeen  = '0;
    reqSeen[0] = wr_req_o;
    rdySeen[0] = wr_ready_o;
    acceptAt = -1;
    overlap  = 0;
    for (int i = 1; i < 20; i++) begin
      acc = res_valid_i && res_ready_o;
      tick();
      if (acc) begin
        res_valid_i = 1'b0;
        acceptAt    = i;
      end
      reqSeen[i] = wr_req_o;
      rdySeen[i] = wr_ready_o;
      if (wr_req_o && wr_ready_o) overlap++;
    end
    checkOutput("t4_reqCycles", reqSeen, 32'h0000_0421);
    checkOutput("t4_readyCycles", rdySeen, 32'h0000_4210);
    checkOutput("t4_acceptAt", acceptAt, 32'd6);
    checkOutput("t4_overlap", overlap, 32'd0);
    checkOutput("t4_busyEnd", {31'd0, busy_o}, 32'd0);

    $display("[TB] hazard detection");
    applyStimulus(1'b1, 5'd7, {32'h74, 32'h73, 32'h72, 32'h71}, 4'hF);
    tick();
    applyStimulus(1'b1, 5'd12, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 4'hF);
    tick();
    applyStimulus(1'b0, 5'd0, 128'd0, 4'd0);
    hazard_addr_i = 5'd12;
    #1 checkOutput("t5_hit12", {31'd0, hazard_o}, 32'd1);
    hazard_addr_i = 5'd4;
    #1 checkOutput("t5_miss4", {31'd0, hazard_o}, 32'd0);
    hazard_addr_i = 5'd7;
    #1 checkOutput("t5_hit7", {31'd0, hazard_o}, 32'd1);
    repeat (5) tick();
    checkOutput("t5_afterA7", {31'd0, hazard_o}, 32'd0);
    hazard_addr_i = 5'd12;
    #1 checkOutput("t5_still12", {31'd0, hazard_o}, 32'd1);
    repeat (5) tick();
    checkOutput("t5_clear12", {31'd0, hazard_o}, 32'd0);
    checkOutput("t5_busyEnd", {31'd0, busy_o}, 32'd0);

    $display("[TB] reset during write");
    applyStimulus(1'b1, 5'd20, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'hF);
    tick();
    applyStimulus(1'b0, 5'd0, 128'd0, 4'd0);
    repeat (3) tick();
    checkOutput("t6_cntBefore", {30'd0, wr_elem_cnt_o}, 32'd1);
    checkOutput("t6_wdataBefore", wdata_o, 32'hD1);
    resetn_i = 1'b0;
    #1;
    checkOutput("t6_en", {31'd0, wr_en_o}, 32'd0);
    checkOutput("t6_cnt", {30'd0, wr_elem_cnt_o}, 32'd0);
    checkOutput("t6_wdata", wdata_o, 32'd0);
    checkOutput("t6_addr", {27'd0, wr_addr_o}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("t6_readyLow", {31'd0, res_ready_o}, 32'd0);
    tick();
    tick();
    #3 resetn_i = 1'b1;
    anyWr = 1'b0;
    repeat (8) begin
      tick();
      anyWr = anyWr | wr_req_o | wr_en_o | wr_ready_o;
    end
    checkOutput("t6_noWrites", {31'd0, anyWr}, 32'd0);
    checkOutput("t6_readyHigh", {31'd0, res_ready_o}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
